// File: rtl/pc_flag_unit_pkg.sv
// pc_flag_unit_pkg: opcodes, condition codes and flag bit positions for the PC/flag unit
package pc_flag_unit_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_UN = 3'b111;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
    typedef enum logic {RUN, HALT} run_state_t;
endpackage

// File: rtl/pc_flag_unit_branch_cond.sv
// branch_cond: evaluates a 3-bit branch condition code against {Z,N,V}
module branch_cond
    import pc_flag_unit_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] ccc,
    output logic       taken
);
    logic z, n, v;
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    always_comb taken = ccc == CC_NE ? !z :
                        ccc == CC_EQ ? z :
                        ccc == CC_GT ? (!z && !n) :
                        ccc == CC_LT ? n :
                        ccc == CC_GE ? (z || (!z && !n)) :
                        ccc == CC_LE ? (n || z) :
                        ccc == CC_OV ? v : ccc == CC_UN;
endmodule

// File: rtl/pc_flag_unit.sv
// pc_flag_unit: architectural PC, Z/N/V flag register and run/halt state for the 16-bit core
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter bit          FLAG_FWD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        id_valid,
    input  logic [3:0]  id_opcode,
    input  logic [2:0]  id_ccc,
    input  logic [8:0]  id_imm9,
    input  logic [15:0] id_rs_data,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        branch_taken,
    output logic        flush,
    output logic        halted,
    output logic [2:0]  flags_q
);
    run_state_t  state;
    logic [2:0]  flags_next, eff;
    logic        ex_all, ex_z, cond, is_b, is_br, halt_accept;
    logic [15:0] b_target, pc_next;
    assign ex_all = ex_valid && (ex_opcode == OP_ADD || ex_opcode == OP_SUB);
    assign ex_z = ex_all || (ex_valid && (ex_opcode inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR}));
    always_comb begin
        flags_next = flags_q;
        flags_next[FLAG_Z] = ex_z ? alu_z : flags_q[FLAG_Z];
        flags_next[FLAG_N] = ex_all ? alu_n : flags_q[FLAG_N];
        flags_next[FLAG_V] = ex_all ? alu_v : flags_q[FLAG_V];
    end
    // Forwarding lets a branch in ID see the flags its EX predecessor is writing this cycle
    assign eff = FLAG_FWD ? flags_next : flags_q;
    branch_cond u_cond (.flags(eff), .ccc(id_ccc), .taken(cond));
    assign is_b = id_opcode == OP_B;
    assign is_br = id_opcode == OP_BR;
    assign branch_taken = rst_n && id_valid && !stall && state == RUN && (is_b || is_br) && cond;
    assign flush = branch_taken;
    assign pc_plus2 = pc + 16'd2;
    assign b_target = pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};
    assign halt_accept = state == RUN && !stall && id_valid && id_opcode == OP_HLT;
    assign pc_next = (state == HALT || stall || halt_accept) ? pc :
                     branch_taken ? (is_b ? b_target : id_rs_data) : pc_plus2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            flags_q <= 3'b000;
            state <= RUN;
            halted <= 1'b0;
        end else begin
            pc <= pc_next;
            flags_q <= flags_next;
            state <= halt_accept ? HALT : state;
            halted <= halted || halt_accept;
        end
    end
endmodule

// File: doc/pc_flag_unit.md
Name: pc_flag_unit

Overview:
- Holds the architectural PC, the Z/N/V flag register and the run/halt state for the 16-bit core.
- Consumes the EX-stage ALU flag outputs (Z, N, V) and updates the flag register according to the opcode.
- Resolves B/BR/HLT for the instruction in ID and produces the next PC plus a flush to IF.
- Sits directly downstream of the ALU on the flag path and upstream of instruction fetch.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLAG_FWD, 1, when 1, flags produced in EX this cycle are forwarded to the branch condition check in ID.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall; freezes the PC and ID-side decisions.
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  opcode of the EX instruction.
- alu_z  in  1  ALU zero flag.
- alu_n  in  1  ALU negative flag.
- alu_v  in  1  ALU overflow flag.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  4  opcode of the ID instruction.
- id_ccc  in  3  branch condition code.
- id_imm9  in  9  signed branch offset, in halfwords.
- id_rs_data  in  16  register target for BR.
- pc  out  16  current fetch PC (registered).
- pc_plus2  out  16  pc + 2, mod 2^16; also used for PCS.
- branch_taken  out  1  combinational; the ID branch is taken this cycle.
- flush  out  1  combinational; kill the instruction in IF (equals branch_taken).
- halted  out  1  registered; the core is halted.
- flags_q  out  3  registered {Z,N,V}.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, flags_q=3'b000, halted=0.
  - branch_taken and flush are 0 while in reset.
  - Reset mid-branch or mid-halt returns to RUN immediately.
- Opcodes: ADD 0000, SUB 0001, XOR 0010, SLL 0100, SRA 0101, ROR 0110, B 1100, BR 1101, PCS 1110, HLT 1111.
- Flag update on clock edge when ex_valid=1, independent of stall:
  - ADD/SUB: Z,N,V all load from alu_z, alu_n, alu_v.
  - XOR/SLL/SRA/ROR: only Z loads; N and V hold.
  - All other opcodes: no change.
- Effective flags (eff):
  - FLAG_FWD=1: eff = flags_q with the fields the EX instruction would update replaced by the live ALU values.
  - FLAG_FWD=0: eff = flags_q.
- Condition evaluation, ccc to condition:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 and N=0
  - 011: N=1
  - 100: Z=1 or (Z=0 and N=0)
  - 101: N=1 or Z=1
  - 110: V=1
  - 111: always
- branch_taken = id_valid & !stall & !halted & (opcode B or BR) & cond(eff).
- Next-PC priority, sampled each edge:
  1. halted: hold.
  2. stall: hold.
  3. id_valid & HLT: hold pc; halted<=1 on the next edge.
  4. B taken: pc <= pc_plus2 + (sext(id_imm9) << 1).
  5. BR taken: pc <= id_rs_data.
  6. Otherwise: pc <= pc_plus2.
- Arithmetic: all PC arithmetic is 16-bit and wraps; e.g. 16'hFFFE + 2 = 16'h0000.
- HLT while stall=1 is not acted on until stall drops.
- halted is sticky until reset. Flags still update from an in-flight EX instruction after halt.
- Simultaneous cases:
  - EX flag-writer and ID branch in the same cycle: forwarding per FLAG_FWD.
  - The flag register edge update still occurs.
- Run/halt FSM: two states, RUN and HALT. RUN goes to HALT on an accepted HLT; HALT goes to RUN only on reset.

Decomposition:
- Shared package: opcode localparams (OP_ADD … OP_HLT), ccc encodings, flag bit indices (FLAG_Z=2, FLAG_N=1, FLAG_V=0).
- One sub-module, branch_cond: purely combinational. Inputs eff flags and ccc; output taken. Reused by the verification scoreboard.

Test Plan:
- Reset release:
  - rst_n low mid-run → pc=0000, flags_q=000, halted=0 asynchronously.
  - After release, no stall → pc 0000, 0002, 0004 on successive edges.
- Flag masking:
  - EX ADD with alu {Z,N,V}=011 → flags_q=011.
  - Then EX XOR with alu_z=1, n=0, v=0 → flags_q=111 (N,V held).
- Forwarded branch:
  - flags_q=000, EX SUB producing Z=1 same cycle, ID B ccc=001, imm9=9'h1FE (−2), pc=0010.
  - FLAG_FWD=1 → branch_taken=1, flush=1, next pc=0012−4=000E.
  - FLAG_FWD=0 → not taken, pc=0012.
- BR and wrap:
  - ID BR ccc=111, id_rs_data=1234 → pc=1234.
  - pc=FFFE, no branch → next pc=0000.
- Stall gating:
  - stall=1 with a taken-condition B → branch_taken=0, pc holds.
  - Release stall → taken on that cycle.
- Halt:
  - ID HLT at pc=0020 → pc stays 0020, halted=1 next edge.
  - Later taken-B inputs ignored.
  - rst_n pulse → RUN, pc=0000.
